mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one read port and one write port of the data Memory block between NUM_REQ in-order superscalar lanes, such as LSU lane 0 and lane 1.
- Uses round-robin arbitration with a valid/ready request handshake and a registered one-cycle response.
- Bounds-checks addresses and blocks out-of-range accesses.
- Sits between the issue/LSU stage and the Memory instance, with NUM_READ_PORTS=1 and NUM_WRITE_PORTS=1.

Parameters:
- NUM_REQ, 2, number of requesting lanes (must be 2 or more).
- DATA_WIDTH, 32, data word width.
- ADDR_WIDTH, 32, word address width.
- MEM_SIZE, 1024, number of words in the attached memory; used for the bounds check.
- CNT_WIDTH, 16, width of the stall counters (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush: drops the pending response and blocks grants this cycle.
- req_valid  in  [NUM_REQ]  lane i has a request.
- req_we  in  [NUM_REQ]  1 = write, 0 = read.
- req_addr  in  [NUM_REQ][ADDR_WIDTH]  word address.
- req_wdata  in  [NUM_REQ][DATA_WIDTH]  write data.
- req_ready  out  [NUM_REQ]  grant; the transfer occurs when valid and ready are both 1.
- rsp_valid  out  [NUM_REQ]  one-cycle response pulse.
- rsp_rdata  out  [DATA_WIDTH]  read data; 0 for writes and errors.
- rsp_err  out  1  access was out of range.
- mem_read_enable  out  1  to Memory read_enable[0].
- mem_read_addr  out  [ADDR_WIDTH]  to Memory read_addr[0].
- mem_read_data  in  [DATA_WIDTH]  from Memory read_data[0]; combinational read.
- mem_write_enable  out  1  to Memory write_enable[0].
- mem_write_addr  out  [ADDR_WIDTH]  to Memory write_addr[0].
- mem_write_data  out  [DATA_WIDTH]  to Memory write_data[0].
- stall_cnt  out  [NUM_REQ][CNT_WIDTH]  exists only with MEM_ARB_STATS_EN.

Behaviour:
- Reset: clk is the clock; reset is synchronous and active-high.
  - rr_ptr=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall_cnt=0.
  - Reset has priority over all other inputs. Reset mid-transaction drops any pending response.
  - No memory enables are asserted while reset=1.
- Grant (combinational each cycle):
  - Winner g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - At most one grant per cycle: req_ready is one-hot or zero.
  - No grant when flush=1 or reset=1.
  - req_ready never depends on a lane's own req_valid beyond selection.
- Requesters hold valid, we, addr and wdata stable until ready. The arbiter does not check this.
- rr_ptr: on any grant, rr_ptr <= (g+1) mod NUM_REQ; otherwise it is unchanged.
- Bounds check: in_range = (req_addr[g] < MEM_SIZE), compared at full ADDR_WIDTH.
- Granted read, in range:
  - mem_read_enable=1 and mem_read_addr=req_addr[g] in the same cycle.
  - mem_read_data is registered into rsp_rdata at posedge.
- Granted write, in range:
  - mem_write_enable=1, with addr and data driven the same cycle.
  - The Memory commits the write at the same posedge.
- Out-of-range access: no memory enable is asserted. The response carries rsp_err=1 and rsp_rdata=0.
- Response timing:
  - Grant in cycle t gives rsp_valid[g]=1 in cycle t+1 only, with rsp_err and rsp_rdata valid.
  - A write response has rsp_rdata=0.
  - Latency is fixed at 1 cycle; throughput is 1 request per cycle.
  - There is no response backpressure: lanes must accept the pulse.
- Enables are 0 and addr/data outputs are 0 when no grant is made.
- Flush:
  - flush=1 in cycle t+1 clears rsp_valid for that cycle; the response registered from cycle t is dropped.
  - A write already committed to memory stays committed.
- Hazard: a write granted at t followed by a read of the same address granted at t+1 returns the new data. No forwarding is needed.
- Lanes with no request never block others. A lone requester is granted every cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined:
  - stall_cnt[i] increments each cycle req_valid[i]=1 and req_ready[i]=0, excluding reset cycles.
  - The counter saturates at all-ones.
  - It clears on reset only; flush does not clear it.
- When undefined: the stall_cnt port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Single read: mem[5]=0xAB, lane0 reads addr 5 at t → req_ready[0]=1 at t; rsp_valid[0]=1, rsp_rdata=0xAB, rsp_err=0 at t+1.
- Contention: both lanes hold valid reads of addr 1 and addr 2 for 4 cycles from reset → grants go 0,1,0,1; responses carry mem[1], mem[2], mem[1], mem[2].
- Write then read: lane1 writes 0x1234 to addr 7 at t, lane0 reads addr 7 at t+1 → lane0's response at t+2 is 0x1234. mem_write_enable is high only at t.
- Out of range: lane0 reads addr 1024 → mem_read_enable stays 0; next cycle rsp_valid[0]=1, rsp_err=1, rsp_rdata=0.
- Flush/reset: grant at t, then flush at t+1 → no rsp_valid at t+1. Reset asserted with both lanes valid → no ready and no enables; first grant after reset goes to lane 0.
- Stats (MEM_ARB_STATS_EN): both lanes continuously valid for 10 cycles → stall_cnt[0]=5 and stall_cnt[1]=5.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-port bundle between LSU lanes, the arbiter and
// the data Memory (one read port, one write port).
// slave  : arbiter side.
// master : lane/memory side.
interface mem_port_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0]                 req_we;
   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]                 req_ready;
   logic [NUM_REQ-1:0]                 rsp_valid;
   logic [DATA_WIDTH-1:0]              rsp_rdata;
   logic                               rsp_err;
   logic                               mem_read_enable;
   logic [ADDR_WIDTH-1:0]              mem_read_addr;
   logic [DATA_WIDTH-1:0]              mem_read_data;
   logic                               mem_write_enable;
   logic [ADDR_WIDTH-1:0]              mem_write_addr;
   logic [DATA_WIDTH-1:0]              mem_write_data;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_read_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_read_enable, mem_read_addr,
             mem_write_enable, mem_write_addr, mem_write_data
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_read_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_read_enable, mem_read_addr,
             mem_write_enable, mem_write_addr, mem_write_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one Memory read port and one write port between
// NUM_REQ LSU lanes.
// - One grant per cycle.
// - Fixed 1-cycle registered response.
// - Out-of-range addresses are answered with rsp_err and never reach memory.
// Optional: define MEM_ARB_STATS_EN to add per-lane saturating stall counters
// (stall_cnt port).
module mem_port_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_SIZE   = 1024,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   mem_port_arbiter_if.slave   bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][CNT_WIDTH-1:0] stall_cnt
`endif
);
   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]      r_rr_ptr;
   logic [NUM_REQ-1:0]    r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;

   logic [PTR_W-1:0]      w_idx;
   logic [PTR_W-1:0]      w_gidx;
   logic                  w_any;
   logic [NUM_REQ-1:0]    w_gnt;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_in_range;
   logic                  w_rd;
   logic                  w_wr;

   // Pick the first valid lane, scanning upward from the round-robin pointer.
   // Flush and reset suppress every grant.
   always_comb begin
      w_any  = 1'b0;
      w_gidx = '0;
      w_idx  = '0;
      if (!reset && !flush) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_any && bus.req_valid[w_idx]) begin
               w_any  = 1'b1;
               w_gidx = w_idx;
            end
         end
      end
   end

   assign w_gnt      = w_any ? (NUM_REQ'(1) << w_gidx) : '0;
   assign w_we       = bus.req_we[w_gidx];
   assign w_addr     = bus.req_addr[w_gidx];
   assign w_wdata    = bus.req_wdata[w_gidx];
   assign w_in_range = (w_addr < ADDR_WIDTH'(MEM_SIZE));
   assign w_rd       = w_any && !w_we && w_in_range;
   assign w_wr       = w_any &&  w_we && w_in_range;

   assign bus.req_ready        = w_gnt;
   assign bus.mem_read_enable  = w_rd;
   assign bus.mem_read_addr    = w_rd ? w_addr : '0;
   assign bus.mem_write_enable = w_wr;
   assign bus.mem_write_addr   = w_wr ? w_addr : '0;
   assign bus.mem_write_data   = w_wr ? w_wdata : '0;

   // A flush (or reset) in the response cycle drops the pending pulse.
   // Committed writes are unaffected.
   assign bus.rsp_valid = r_rsp_valid & {NUM_REQ{~(flush | reset)}};
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;

   // Register the response for the granted lane and advance the pointer past
   // the winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr    <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_gnt;
         r_rsp_rdata <= w_rd ? bus.mem_read_data : '0;
         r_rsp_err   <= w_any && !w_in_range;
         if (w_any)
            r_rr_ptr <= PTR_W'((int'(w_gidx) + 1) % NUM_REQ);
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [NUM_REQ-1:0][CNT_WIDTH-1:0] r_stall_cnt;

   // Count cycles each lane waits with a request up.
   // Saturates at all-ones; cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_valid[i] && !w_gnt[i] && r_stall_cnt[i] != '1)
               r_stall_cnt[i] <= r_stall_cnt[i] + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter.
// - Directed scenarios are followed by random traffic.
// - A transaction-level model predicts grants, memory port activity and
//   responses.
// - A behavioural memory hangs off the memory port.
module tb_mem_port_arbiter;
   localparam int N   = 2;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int MSZ = 1024;
   localparam int CW  = 16;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef MEM_ARB_STATS_EN
   logic [N-1:0][CW-1:0] stall_cnt;
`endif

   mem_port_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MSZ), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus)
`ifdef MEM_ARB_STATS_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   // environment memory, combinational read
   logic [DW-1:0] env_mem [MSZ];
   logic [DW-1:0] ref_mem [MSZ];
   assign bus.mem_read_data = (bus.mem_read_addr < AW'(MSZ)) ? env_mem[bus.mem_read_addr[9:0]] : '0;

   int n_vec = 0;
   int n_err = 0;

   // reference state
   int            ref_ptr;
   logic [N-1:0]  pend_vld;
   logic          pend_err;
   logic [DW-1:0] pend_rdata;
   int            exp_stall [N];

   // staged stimulus
   logic [N-1:0]  s_valid;
   logic [N-1:0]  s_we;
   logic [AW-1:0] s_addr  [N];
   logic [DW-1:0] s_wdata [N];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic idle();
      s_valid = '0;
      s_we    = '0;
      for (int i = 0; i < N; i++) begin
         s_addr[i]  = '0;
         s_wdata[i] = '0;
      end
   endtask

   task automatic req(input int lane, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      s_valid[lane] = 1'b1;
      s_we[lane]    = we;
      s_addr[lane]  = a;
      s_wdata[lane] = d;
   endtask

   // one cycle: apply stimulus, check outputs against model, advance model
   task automatic step(input logic rst, input logic fl);
      int g;
      logic inr;
      logic [N-1:0] e_rdy;
      logic e_rd, e_wr;
      logic [AW-1:0] ga;
      @(negedge clk);
      reset = rst;
      flush = fl;
      bus.req_valid = s_valid;
      bus.req_we    = s_we;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i]  = s_addr[i];
         bus.req_wdata[i] = s_wdata[i];
      end
      #1;
      g = -1;
      if (!rst && !fl)
         for (int k = 0; k < N; k++)
            if (g < 0 && s_valid[(ref_ptr + k) % N]) g = (ref_ptr + k) % N;
      e_rdy = '0;
      e_rd = 1'b0;
      e_wr = 1'b0;
      inr = 1'b0;
      ga = '0;
      if (g >= 0) begin
         e_rdy[g] = 1'b1;
         ga  = s_addr[g];
         inr = (ga < AW'(MSZ));
         e_rd = inr && !s_we[g];
         e_wr = inr &&  s_we[g];
      end
      chk("req_ready", 64'(bus.req_ready), 64'(e_rdy));
      chk("rd_en",     64'(bus.mem_read_enable),  64'(e_rd));
      chk("rd_addr",   64'(bus.mem_read_addr),    e_rd ? 64'(ga) : 64'd0);
      chk("wr_en",     64'(bus.mem_write_enable), 64'(e_wr));
      chk("wr_addr",   64'(bus.mem_write_addr),   e_wr ? 64'(ga) : 64'd0);
      chk("wr_data",   64'(bus.mem_write_data),   e_wr ? 64'(s_wdata[g]) : 64'd0);
      chk("rsp_valid", 64'(bus.rsp_valid), (rst || fl) ? 64'd0 : 64'(pend_vld));
      chk("rsp_err",   64'(bus.rsp_err),   64'(pend_err));
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(pend_rdata));
`ifdef MEM_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("stall_cnt", 64'(stall_cnt[i]), 64'(exp_stall[i]));
`endif
      // environment memory captures what the DUT actually drove
      if (bus.mem_write_enable && bus.mem_write_addr < AW'(MSZ))
         env_mem[bus.mem_write_addr[9:0]] = bus.mem_write_data;
      // advance model
      if (rst) begin
         ref_ptr = 0;
         pend_vld = '0;
         pend_err = 1'b0;
         pend_rdata = '0;
         for (int i = 0; i < N; i++) exp_stall[i] = 0;
      end else begin
         for (int i = 0; i < N; i++)
            if (s_valid[i] && !e_rdy[i] && exp_stall[i] < (1 << CW) - 1) exp_stall[i]++;
         pend_vld   = e_rdy;
         pend_err   = (g >= 0) && !inr;
         pend_rdata = e_rd ? ref_mem[ga[9:0]] : '0;
         if (e_wr) ref_mem[ga[9:0]] = s_wdata[g];
         if (g >= 0) ref_ptr = (g + 1) % N;
      end
   endtask

   initial begin
      for (int i = 0; i < MSZ; i++) begin
         env_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
         ref_mem[i] = env_mem[i];
      end
      env_mem[5] = 32'hAB;
      ref_mem[5] = 32'hAB;
      ref_ptr = 0;
      pend_vld = '0;
      pend_err = 1'b0;
      pend_rdata = '0;
      for (int i = 0; i < N; i++) exp_stall[i] = 0;
      reset = 1'b1;
      flush = 1'b0;
      idle();

      // reset with both lanes requesting: no grants, no enables
      req(0, 1'b0, 32'd1, '0);
      req(1, 1'b1, 32'd2, 32'h55);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);

      // single read of addr 5
      idle();
      req(0, 1'b0, 32'd5, '0);
      step(1'b0, 1'b0);
      idle();
      step(1'b0, 1'b0);

      // contention from reset: grants 0,1,0,1
      step(1'b1, 1'b0);
      req(0, 1'b0, 32'd1, '0);
      req(1, 1'b0, 32'd2, '0);
      repeat (4) step(1'b0, 1'b0);
      idle();
      step(1'b0, 1'b0);

      // write then read same address
      req(1, 1'b1, 32'd7, 32'h1234);
      step(1'b0, 1'b0);
      idle();
      req(0, 1'b0, 32'd7, '0);
      step(1'b0, 1'b0);
      idle();
      step(1'b0, 1'b0);

      // out-of-range reads and writes
      req(0, 1'b0, 32'd1024, '0);
      step(1'b0, 1'b0);
      idle();
      req(1, 1'b1, 32'hFFFF_FFFF, 32'hDEAD);
      step(1'b0, 1'b0);
      idle();
      step(1'b0, 1'b0);

      // grant then flush: response dropped
      req(0, 1'b0, 32'd3, '0);
      step(1'b0, 1'b0);
      idle();
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      // both lanes valid for 10 cycles from reset (stall counters 5/5)
      step(1'b1, 1'b0);
      req(0, 1'b0, 32'd10, '0);
      req(1, 1'b0, 32'd11, '0);
      repeat (10) step(1'b0, 1'b0);
      idle();
      step(1'b0, 1'b0);

      // random traffic
      for (int c = 0; c < 400; c++) begin
         idle();
         for (int i = 0; i < N; i++) begin
            logic [AW-1:0] a;
            case ($urandom_range(7))
               0:       a = 32'd1024;
               1:       a = 32'd1023;
               2:       a = $urandom;
               default: a = AW'($urandom_range(15));
            endcase
            if ($urandom_range(3) != 0)
               req(i, ($urandom_range(2) == 0), a, $urandom);
         end
         step(($urandom_range(49) == 0), ($urandom_range(15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
